multi_channel_controller: RTL

Time-multiplexed sequencing controller serving NUM_CHANNELS voices from one shared pattern sequencer, pitch lookup, duration counter bank and envelope bank. On each tick strobe it sweeps channels 0..NUM_CHANNELS-1 in order. For each channel it either starts a new note or advances the current one. Sits between the tick/note timebase and the per-channel datapath, which is indexed by o_channel.

---
 rtl/multi_channel_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multi_channel_controller.sv
// multi_channel_controller
//
// Time-multiplexed sequencer front end. On each accepted tick it sweeps the
// channels 0..NUM_CHANNELS-1 in order. For each channel it either starts a new
// note or advances the note already playing. A new note runs through
// pattern fetch, pitch lookup, and then loads the duration counter and the
// envelope. The shared datapath entry for the channel being serviced is
// selected by o_channel.
//
// Optional feature: define MULTI_CHANNEL_CONTROLLER_MUTE_EN to add i_mute. A
// muted channel is skipped in one cycle, issues no strobes, and loses its
// active bit, so it starts again on the first note strobe after it is unmuted.
//
// Ports
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_tick_stb, i_note_stb  tick starts a sweep; note is latched with the tick
//   i_mute                  per-channel mute (MUTE_EN builds only)
//   o_channel               channel being serviced (holds its value in IDLE)
//   o_busy, o_overrun       sweep in progress; pulse when a tick is dropped
//   o_pattern_enable / i_pattern_valid            pattern fetch handshake
//   o_pitch_lookup_enable / i_pitch_lookup_valid  pitch lookup handshake
//   o_duration_enable, o_duration_load, i_duration_running  duration counter
//   o_envelope_enable, o_envelope_load            envelope advance/restart
//
// state        | meaning
// IDLE         | waiting for a tick
// DISPATCH     | choose between starting a note and advancing the channel
// EN_PATTERN   | pattern fetch strobe
// WAIT_PATTERN | waiting for the pattern fetch to complete
// EN_PITCH     | pitch lookup strobe
// WAIT_PITCH   | waiting for the pitch lookup to complete
// LOAD         | load duration and restart envelope; mark channel active
// ADVANCE      | step envelope (and duration when a note strobe came with the tick)

module multi_channel_controller #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick_stb,
  input  logic                    i_note_stb,
`ifdef MULTI_CHANNEL_CONTROLLER_MUTE_EN
  input  logic [NUM_CHANNELS-1:0] i_mute,
`endif
  output logic [CH_WIDTH-1:0]     o_channel,
  output logic                    o_busy,
  output logic                    o_overrun,
  output logic                    o_pattern_enable,
  input  logic                    i_pattern_valid,
  output logic                    o_pitch_lookup_enable,
  input  logic                    i_pitch_lookup_valid,
  output logic                    o_duration_enable,
  output logic                    o_duration_load,
  input  logic                    i_duration_running,
  output logic                    o_envelope_enable,
  output logic                    o_envelope_load
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DISPATCH     = 3'd1,
    EN_PATTERN   = 3'd2,
    WAIT_PATTERN = 3'd3,
    EN_PITCH     = 3'd4,
    WAIT_PITCH   = 3'd5,
    LOAD         = 3'd6,
    ADVANCE      = 3'd7
  } state_t;

  localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CH_WIDTH-1:0] CH_ONE  = CH_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [CH_WIDTH-1:0]     ch_q, ch_d;
  logic                    note_q, note_d;
  logic [NUM_CHANNELS-1:0] active_q, active_d;
  logic                    muted;
  logic                    next_ch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      note_q   <= 1'b0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      note_q   <= note_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    ch_d                  = ch_q;
    note_d                = note_q;
    active_d              = active_q;
    next_ch               = 1'b0;
    o_pattern_enable      = 1'b0;
    o_pitch_lookup_enable = 1'b0;
    o_duration_enable     = 1'b0;
    o_duration_load       = 1'b0;
    o_envelope_enable     = 1'b0;
    o_envelope_load       = 1'b0;
`ifdef MULTI_CHANNEL_CONTROLLER_MUTE_EN
    muted                 = i_mute[ch_q];
`else
    muted                 = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (i_tick_stb) begin
          note_d  = i_note_stb;
          ch_d    = '0;
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        if (muted) begin
          active_d[ch_q] = 1'b0;
          next_ch        = 1'b1;
        end else if (note_q && (!active_q[ch_q] || !i_duration_running)) begin
          state_d = EN_PATTERN;
        end else begin
          state_d = ADVANCE;
        end
      end
      EN_PATTERN: begin
        o_pattern_enable = 1'b1;
        state_d          = WAIT_PATTERN;
      end
      WAIT_PATTERN: begin
        if (i_pattern_valid) state_d = EN_PITCH;
      end
      EN_PITCH: begin
        o_pitch_lookup_enable = 1'b1;
        state_d               = WAIT_PITCH;
      end
      WAIT_PITCH: begin
        if (i_pitch_lookup_valid) state_d = LOAD;
      end
      LOAD: begin
        o_duration_enable = 1'b1;
        o_duration_load   = 1'b1;
        o_envelope_enable = 1'b1;
        o_envelope_load   = 1'b1;
        active_d[ch_q]    = 1'b1;
        next_ch           = 1'b1;
      end
      ADVANCE: begin
        o_envelope_enable = 1'b1;
        o_duration_enable = note_q;
        next_ch           = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Leaving a channel: the last one ends the sweep and ch stays put so
    // o_channel holds in IDLE.
    if (next_ch) begin
      if (ch_q == LAST_CH) begin
        state_d = IDLE;
      end else begin
        ch_d    = ch_q + CH_ONE;
        state_d = DISPATCH;
      end
    end
  end

  assign o_channel = ch_q;
  assign o_busy    = (state_q != IDLE);
  // A tick in the cycle the FSM is back in IDLE is accepted, not dropped.
  assign o_overrun = i_tick_stb && (state_q != IDLE) && !i_rst;

endmodule
